// File: rtl/vga_pkg.sv
// vga_pkg: shared display constants, fetch FSM encoding and address helper.
package vga_pkg;

  localparam int unsigned H_VALID       = 640;
  localparam int unsigned V_VALID       = 480;
  localparam logic [9:0]  COORD_INVALID = 10'h3ff;

  localparam int unsigned RGB565_W  = 16;
  localparam int unsigned SRC_W_DEF = 160;
  localparam int unsigned SRC_H_DEF = 120;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_st_e;

  // row * width as a sum of shifted copies of row (width is a constant, so this folds to a few adders)
  function automatic logic [31:0] row_base(input logic [31:0] row, input int unsigned width);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++) begin
      if (width[i]) acc = acc + (row << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/vga_line_buf.sv
// vga_line_buf: two ping-pong line buffers, synchronous write (fetch) and registered read (display).
module vga_line_buf #(
  parameter int unsigned DEPTH = 160,
  parameter int unsigned DW    = 16,
  parameter int unsigned CW    = 8
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic          wbuf_i,
  input  logic [CW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic          rbuf_i,
  input  logic [CW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2][DEPTH];
  logic [DW-1:0] rdata_q;

  // Fetch-side write port
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wbuf_i][waddr_i] <= wdata_i;
  end

  // Display-side read; blanks to zero when the coordinate is outside the active area
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[rbuf_i][raddr_i];
    else           rdata_q <= '0;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_line_fetch.sv
// vga_line_fetch: prefetches source rows into ping-pong line buffers and serves 4x-upscaled pixels.
module vga_line_fetch
  import vga_pkg::*;
#(
  parameter int unsigned SRC_W    = SRC_W_DEF,
  parameter int unsigned SRC_H    = SRC_H_DEF,
  parameter int unsigned SCALE_SH = 2,
  parameter int unsigned AW       = 15,
  parameter int unsigned DW       = RGB565_W
) (
  input  logic          vga_clk,
  input  logic          rst_n,
  input  logic          vsync,
  input  logic [9:0]    pic_x,
  input  logic [9:0]    pic_y,
  output logic [DW-1:0] pic_data,
  output logic          rd_req,
  output logic [AW-1:0] rd_addr,
  input  logic          rd_gnt,
  input  logic          rd_valid,
  input  logic [DW-1:0] rd_data,
  output logic          underrun
);

  localparam int unsigned CW = $clog2(SRC_W);
  localparam int unsigned RW = $clog2(SRC_H);

  fetch_st_e     state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [RW-1:0] pend_row_q, pend_row_d;
  logic [CW-1:0] col_q, col_d;
  logic [1:0]    buf_ok_q, buf_ok_d;
  logic          pend_q, pend_d;
  logic          rd_req_q, rd_req_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          underrun_q, underrun_d;
  logic          vsync_q;

  logic          frame_c, active_c, line_trig_c, fetch_trig_c;
  logic          start_c, wr_en_c;
  logic [RW-1:0] line_row_c, trig_row_c, start_row_c;

  // Trigger decode: vsync rising edge restarts at row 0, each source-row boundary prefetches the next row
  assign frame_c      = vsync & ~vsync_q;
  assign active_c     = (pic_x < 10'(H_VALID)) && (pic_y < 10'(V_VALID));
  assign line_trig_c  = (pic_x == '0) && (pic_y < 10'(V_VALID)) && (pic_y[SCALE_SH-1:0] == '0);
  assign line_row_c   = RW'(pic_y >> SCALE_SH);
  assign fetch_trig_c = frame_c || (line_trig_c && (line_row_c < RW'(SRC_H - 1)));
  assign trig_row_c   = frame_c ? '0 : line_row_c + RW'(1);

  // Fetch FSM next state: one outstanding word, pending trigger replaces the row at the next response
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    buf_ok_d    = buf_ok_q;
    pend_d      = pend_q;
    pend_row_d  = pend_row_q;
    rd_req_d    = rd_req_q;
    rd_addr_d   = rd_addr_q;
    underrun_d  = underrun_q;
    wr_en_c     = 1'b0;
    start_c     = 1'b0;
    start_row_c = '0;

    if (line_trig_c && !buf_ok_q[line_row_c[0]]) underrun_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (fetch_trig_c) begin
          start_c     = 1'b1;
          start_row_c = trig_row_c;
        end else if (pend_q) begin
          start_c     = 1'b1;
          start_row_c = pend_row_q;
        end
      end
      ST_REQ: begin
        if (fetch_trig_c) begin
          pend_d     = 1'b1;
          pend_row_d = trig_row_c;
        end
        if (rd_gnt) begin
          rd_req_d = 1'b0;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (fetch_trig_c) begin
          pend_d     = 1'b1;
          pend_row_d = trig_row_c;
        end
        if (rd_valid) begin
          wr_en_c = 1'b1;
          if (col_q == CW'(SRC_W - 1)) begin
            buf_ok_d[row_q[0]] = 1'b1;
            state_d            = ST_IDLE;
          end else begin
            col_d     = col_q + CW'(1);
            rd_addr_d = rd_addr_q + AW'(1);
            rd_req_d  = 1'b1;
            state_d   = ST_REQ;
          end
          if (pend_d) begin
            start_c     = 1'b1;
            start_row_c = pend_row_d;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Fetch start: a restarted buffer is invalid until its last word lands
    if (start_c) begin
      row_d                  = start_row_c;
      col_d                  = '0;
      buf_ok_d[start_row_c[0]] = 1'b0;
      pend_d                 = 1'b0;
      rd_req_d               = 1'b1;
      rd_addr_d              = AW'(row_base(32'(start_row_c), SRC_W));
      state_d                = ST_REQ;
    end
  end

  // State and registered outputs
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      buf_ok_q   <= '0;
      pend_q     <= 1'b0;
      pend_row_q <= '0;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= '0;
      underrun_q <= 1'b0;
      vsync_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      buf_ok_q   <= buf_ok_d;
      pend_q     <= pend_d;
      pend_row_q <= pend_row_d;
      rd_req_q   <= rd_req_d;
      rd_addr_q  <= rd_addr_d;
      underrun_q <= underrun_d;
      vsync_q    <= vsync;
    end
  end

  vga_line_buf #(
    .DEPTH (SRC_W),
    .DW    (DW),
    .CW    (CW)
  ) u_line_buf (
    .clk_i   (vga_clk),
    .rst_n   (rst_n),
    .we_i    (wr_en_c),
    .wbuf_i  (row_q[0]),
    .waddr_i (col_q),
    .wdata_i (rd_data),
    .re_i    (active_c),
    .rbuf_i  (pic_y[SCALE_SH]),
    .raddr_i (CW'(pic_x >> SCALE_SH)),
    .rdata_o (pic_data)
  );

  assign rd_req   = rd_req_q;
  assign rd_addr  = rd_addr_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_vga_line_fetch.sv
// tb_vga_line_fetch: directed + randomized checks of the line prefetcher against a frame-memory model.
module tb_vga_line_fetch;

  logic        vga_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic        vsync   = 1'b0;
  logic [9:0]  pic_x   = 10'h3ff;
  logic [9:0]  pic_y   = 10'h3ff;
  logic [15:0] pic_data;
  logic        rd_req;
  logic [14:0] rd_addr;
  logic        rd_gnt;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        underrun;

  int total = 0;
  int bad   = 0;

  // Frame memory model and responder knobs
  logic [15:0] mem [32768];
  int          gdel     = 0;
  int          lat      = 1;
  bit          rnd_mode = 1'b0;
  int          addr_log [$];

  int base, errs, n, x, y, expv;
  bit found;

  always #20 vga_clk = ~vga_clk;

  vga_line_fetch dut (
    .vga_clk  (vga_clk),
    .rst_n    (rst_n),
    .vsync    (vsync),
    .pic_x    (pic_x),
    .pic_y    (pic_y),
    .pic_data (pic_data),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_gnt   (rd_gnt),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .underrun (underrun)
  );

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic set_xy(input int xi, input int yi);
    pic_x = 10'(xi);
    pic_y = 10'(yi);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int log_at(input int i);
    if (i < 0 || i >= addr_log.size()) return -1;
    return addr_log[i];
  endfunction

  task automatic wait_ok(input int b, input int budget, input string tag);
    int k;
    k = 0;
    while (dut.buf_ok_q[b] !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    chk(tag, 32'(dut.buf_ok_q[b]), 32'd1);
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    step();
    step();
    vsync = 1'b0;
  endtask

  task automatic chk_row_seq(input string tag, input int first, input int row);
    int e;
    e = 0;
    chk({tag, "_len"}, 32'(addr_log.size() - first), 32'd160);
    for (int i = 0; i < 160; i++) begin
      if (log_at(first + i) != row * 160 + i) e++;
    end
    chk({tag, "_addr"}, 32'(e), 32'd0);
  endtask

  // Memory responder: grants after a delay, returns mem[addr] a fixed/random latency after the grant
  initial begin : mem_model
    int gcnt, gtarget, vcnt, cur_lat;
    bit busy;
    logic [15:0] dq;
    rd_gnt = 1'b0; rd_valid = 1'b0; rd_data = '0;
    gcnt = 0; gtarget = 0; vcnt = 0; cur_lat = 1; busy = 1'b0; dq = '0;
    forever begin
      step();
      rd_valid = 1'b0;
      if (rd_gnt) begin
        rd_gnt  = 1'b0;
        cur_lat = rnd_mode ? int'($urandom_range(1, 4)) : lat;
        if (cur_lat <= 1) begin
          rd_valid = 1'b1;
          rd_data  = dq;
        end else begin
          busy = 1'b1;
          vcnt = cur_lat - 1;
        end
      end else if (busy) begin
        vcnt--;
        if (vcnt == 0) begin
          busy     = 1'b0;
          rd_valid = 1'b1;
          rd_data  = dq;
        end
      end else if (rd_req === 1'b1) begin
        if (gcnt == 0) gtarget = rnd_mode ? int'($urandom_range(0, 3)) : gdel;
        if (gcnt >= gtarget) begin
          rd_gnt = 1'b1;
          dq     = mem[rd_addr];
          addr_log.push_back(int'(rd_addr));
          gcnt   = 0;
        end else begin
          gcnt++;
        end
      end
    end
  end

  initial begin : stim
    for (int a = 0; a < 32768; a++) mem[a] = 16'(a);

    // Reset state
    step(); step(); step();
    chk("rst_rd_req", 32'(rd_req), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_pic_data", 32'(pic_data), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_buf_ok", 32'(dut.buf_ok_q), 32'd0);
    rst_n = 1'b1;
    step(); step();

    // Frame start fetches row 0
    vsync_pulse();
    wait_ok(0, 1000, "a_row0_ok");
    chk_row_seq("a_row0", 0, 0);
    chk("a_underrun", 32'(underrun), 32'd0);

    // Walk every source row boundary of a frame, waiting out each prefetch
    set_xy(0, 0); step();
    set_xy(5, 0); step();
    chk("b_pix_5_0", 32'(pic_data), 32'd1);
    set_xy(1023, 1023);
    wait_ok(1, 1000, "b_row1_ok");
    for (int r = 1; r < 120; r++) begin
      if (r == 1) base = addr_log.size();
      set_xy(0, 4 * r); step();
      set_xy(1023, 1023);
      if (r < 119) wait_ok((r + 1) % 2, 1000, "b_row_ok");
      if (r == 1) chk_row_seq("b_row2", base, 2);
    end
    set_xy(639, 479); step();
    chk("b_pix_639_479", 32'(pic_data), 32'd19199);
    set_xy(640, 100); step();
    chk("b_pix_x640", 32'(pic_data), 32'd0);
    set_xy(100, 480); step();
    chk("b_pix_y480", 32'(pic_data), 32'd0);
    set_xy(1023, 1023); step();
    chk("b_pix_invalid", 32'(pic_data), 32'd0);
    chk("b_underrun", 32'(underrun), 32'd0);

    // Random image, random grant delay and latency; sample pixels of resident rows
    rnd_mode = 1'b1;
    for (int a = 0; a < 19200; a++) mem[a] = 16'($urandom);
    vsync_pulse();
    wait_ok(0, 4000, "c_row0_ok");
    for (int r = 0; r < 10; r++) begin
      set_xy(0, 4 * r); step();
      set_xy(1023, 1023);
      wait_ok((r + 1) % 2, 4000, "c_row_ok");
      for (int s = 0; s < 8; s++) begin
        x = int'($urandom_range(0, 639));
        y = 4 * r + int'($urandom_range(0, 7));
        if (x == 0 && (y % 4) == 0) x = 1;
        expv = int'(mem[(y / 4) * 160 + (x / 4)]);
        set_xy(x, y); step();
        chk("c_rnd_pix", 32'(pic_data), 32'(expv));
      end
      set_xy(1023, 1023);
    end
    chk("c_underrun", 32'(underrun), 32'd0);
    rnd_mode = 1'b0;

    // Frame start while row 37 col 10 is being requested
    for (int a = 0; a < 19200; a++) mem[a] = 16'(a);
    gdel = 5;
    set_xy(0, 144); step();
    set_xy(1023, 1023);
    found = 1'b0;
    n = 0;
    while (!found && n < 500) begin
      if (rd_req === 1'b1 && rd_addr === 15'(37 * 160 + 10)) found = 1'b1;
      else begin step(); n++; end
    end
    chk("d_req_col10_seen", 32'(found), 32'd1);
    base = addr_log.size();
    vsync = 1'b1;
    step(); step();
    vsync = 1'b0;
    repeat (20) step();
    wait_ok(0, 3000, "d_row0_ok");
    chk("d_log_len", 32'(addr_log.size() - base), 32'd161);
    chk("d_col10_granted", 32'(log_at(base)), 32'd5930);
    chk("d_restart_addr", 32'(log_at(base + 1)), 32'd0);
    chk("d_buf1_not_ok", 32'(dut.buf_ok_q[1]), 32'd0);
    set_xy(0, 144); step();
    set_xy(1023, 1023);
    wait_ok(1, 3000, "d_row37_ok");
    set_xy(40, 148); step();
    chk("d_pix_row37", 32'(pic_data), 32'd5930);
    set_xy(1023, 1023);

    // Reset while a response is outstanding; the late word must not land
    gdel = 0;
    lat  = 20;
    mem[37 * 160] = 16'hbeef;
    set_xy(0, 144); step();
    set_xy(0, 148); step();
    set_xy(1, 148); step();
    chk("e_underrun_set", 32'(underrun), 32'd1);
    chk("e_in_wait", 32'(rd_req), 32'd0);
    rst_n = 1'b0;
    step();
    chk("e_rst_rd_req", 32'(rd_req), 32'd0);
    chk("e_rst_pic_data", 32'(pic_data), 32'd0);
    chk("e_rst_underrun", 32'(underrun), 32'd0);
    chk("e_rst_buf_ok", 32'(dut.buf_ok_q), 32'd0);
    step();
    rst_n = 1'b1;
    repeat (25) step();
    chk("e_idle_after_late", 32'(rd_req), 32'd0);
    chk("e_no_write", 32'(pic_data), 32'd5920);
    set_xy(1023, 1023);

    // Slow memory: row 1 cannot finish before its lines are displayed
    lat = 25;
    step();
    vsync_pulse();
    wait_ok(0, 6000, "f_row0_ok");
    set_xy(0, 0); step();
    set_xy(1023, 1023);
    chk("f_no_underrun_y0", 32'(underrun), 32'd0);
    repeat (3198) step();
    set_xy(0, 4); step();
    set_xy(1023, 1023);
    chk("f_underrun_rise", 32'(underrun), 32'd1);
    repeat (100) step();
    vsync_pulse();
    repeat (100) step();
    wait_ok(0, 6000, "f_row0_again_ok");
    chk("f_underrun_sticky", 32'(underrun), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
